// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: two requester ports and the data-memory side.
// Perf counter signals exist only when DMEM_ARB_PERF_EN is defined.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              m0_req;
  logic [BE_W-1:0]   m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [BE_W-1:0]   m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0]       m0_grants;
  logic [31:0]       m1_grants;
  logic [31:0]       m0_stalls;
  logic [31:0]       m1_stalls;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output m0_grants, m1_grants, m0_stalls, m1_stalls
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  m0_grants, m1_grants, m0_stalls, m1_stalls
  );
`else
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter in front of single-port dmem, one read in flight.
// Optional per-requester grant/stall counters under DMEM_ARB_PERF_EN.
//
// state   | meaning
// IDLE    | grants accepted; writes complete here, a read moves to RD_WAIT
// RD_WAIT | read in flight; cnt counts down to the mem_rdata capture cycle
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt0, gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rvalid_d = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state_q)
      IDLE: begin
        // on a tie the requester that did not win last time goes first
        if (bus.m0_req && (!bus.m1_req || last_q)) gnt0 = 1'b1;
        else if (bus.m1_req)                       gnt1 = 1'b1;
        if (gnt0 || gnt1) begin
          last_d = gnt1;
          if ((gnt0 && bus.m0_we == '0) || (gnt1 && bus.m1_we == '0)) begin
            owner_d = gnt1;
            cnt_d   = CNT_LOAD;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rvalid_d = owner_q ? 2'b10 : 2'b01;
          if (owner_q) rdata1_d = bus.mem_rdata;
          else         rdata0_d = bus.mem_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = gnt0 | gnt1;
  assign bus.mem_we    = gnt0 ? bus.m0_we    : (gnt1 ? bus.m1_we    : '0);
  assign bus.mem_addr  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : '0);
  assign bus.mem_wdata = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : '0);

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] m0_grants_q, m1_grants_q, m0_stalls_q, m1_stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_grants_q <= '0;
      m1_grants_q <= '0;
      m0_stalls_q <= '0;
      m1_stalls_q <= '0;
    end else begin
      if (gnt0)                m0_grants_q <= m0_grants_q + 32'd1;
      if (gnt1)                m1_grants_q <= m1_grants_q + 32'd1;
      if (bus.m0_req && !gnt0) m0_stalls_q <= m0_stalls_q + 32'd1;
      if (bus.m1_req && !gnt1) m1_stalls_q <= m1_stalls_q + 32'd1;
    end
  end

  assign bus.m0_grants = m0_grants_q;
  assign bus.m1_grants = m1_grants_q;
  assign bus.m0_stalls = m0_stalls_q;
  assign bus.m1_stalls = m1_stalls_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream,
// each checked every cycle against a cycle-count/queue-level model plus literal pins.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        r0, r1;
  logic [3:0]  w0, w1;
  logic [31:0] a0, a1, wd0, wd1;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  assign bus1.m0_req = r0;  assign bus1.m0_we = w0;  assign bus1.m0_addr = a0;  assign bus1.m0_wdata = wd0;
  assign bus1.m1_req = r1;  assign bus1.m1_we = w1;  assign bus1.m1_addr = a1;  assign bus1.m1_wdata = wd1;
  assign bus3.m0_req = r0;  assign bus3.m0_we = w0;  assign bus3.m0_addr = a0;  assign bus3.m0_wdata = wd0;
  assign bus3.m1_req = r1;  assign bus3.m1_we = w1;  assign bus3.m1_addr = a1;  assign bus3.m1_wdata = wd1;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'h12345678;
      default: return a ^ 32'h5A5A0F0F;
    endcase
  endfunction

  // Memory models: data for a command appears RD_LAT cycles later.
  logic [31:0] p1 = '0, p3a = '0, p3b = '0, p3c = '0;
  always @(posedge clk) begin
    p1  <= bus1.mem_addr;
    p3a <= bus3.mem_addr;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign bus1.mem_rdata = rd_word(p1);
  assign bus3.mem_rdata = rd_word(p3c);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        g0, g1, rv0, rv1, en;
    logic [3:0]  mwe;
    logic [31:0] rd0, rd1, maddr, mwd;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] gr0, gr1, st0, st1;
`endif
  } obs_t;

  // Model state, index 0 = RD_LAT 1 instance, index 1 = RD_LAT 3 instance.
  int          cyc;
  int          last_g [2];
  bit          pv     [2];
  int          pown   [2];
  int          pdue   [2];
  logic [31:0] paddr  [2];
  logic [31:0] mrd    [2][2];
  logic [31:0] mgr    [2][2];
  logic [31:0] mst    [2][2];

  task automatic model_reset();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      last_g[d] = 1;
      pv[d]     = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mrd[d][k] = '0;
        mgr[d][k] = '0;
        mst[d][k] = '0;
      end
    end
  endtask

  task automatic model_cycle(input int d, input int lat, input obs_t o);
    int          w;
    bit          busy;
    logic [1:0]  erv;
    logic [3:0]  ewe;
    logic [31:0] ea, ewd;
    string       p;
    p    = (lat == 1) ? "lat1" : "lat3";
    erv  = '0;
    busy = pv[d] && (cyc < pdue[d]);
    if (pv[d] && cyc == pdue[d]) begin
      erv[pown[d]]     = 1'b1;
      mrd[d][pown[d]]  = rd_word(paddr[d]);
      pv[d]            = 1'b0;
    end
    w = -1;
    if (!busy) begin
      if (r0 && r1) w = (last_g[d] == 1) ? 0 : 1;
      else if (r0)  w = 0;
      else if (r1)  w = 1;
    end
    case (w)
      0:       begin ewe = w0; ea = a0; ewd = wd0; end
      1:       begin ewe = w1; ea = a1; ewd = wd1; end
      default: begin ewe = '0; ea = '0; ewd = '0; end
    endcase
    chk({p, " m0_gnt"},    o.g0,    32'(w == 0));
    chk({p, " m1_gnt"},    o.g1,    32'(w == 1));
    chk({p, " mem_en"},    o.en,    32'(w >= 0));
    chk({p, " mem_we"},    o.mwe,   ewe);
    chk({p, " mem_addr"},  o.maddr, ea);
    chk({p, " mem_wdata"}, o.mwd,   ewd);
    chk({p, " m0_rvalid"}, o.rv0,   erv[0]);
    chk({p, " m1_rvalid"}, o.rv1,   erv[1]);
    chk({p, " m0_rdata"},  o.rd0,   mrd[d][0]);
    chk({p, " m1_rdata"},  o.rd1,   mrd[d][1]);
`ifdef DMEM_ARB_PERF_EN
    chk({p, " m0_grants"}, o.gr0,   mgr[d][0]);
    chk({p, " m1_grants"}, o.gr1,   mgr[d][1]);
    chk({p, " m0_stalls"}, o.st0,   mst[d][0]);
    chk({p, " m1_stalls"}, o.st1,   mst[d][1]);
    if (r0 && w != 0) mst[d][0] = mst[d][0] + 32'd1;
    if (r1 && w != 1) mst[d][1] = mst[d][1] + 32'd1;
`endif
    if (w >= 0) begin
      mgr[d][w] = mgr[d][w] + 32'd1;
      last_g[d] = w;
      if (ewe == '0) begin
        pv[d]    = 1'b1;
        pown[d]  = w;
        pdue[d]  = cyc + lat + 1;
        paddr[d] = ea;
      end
    end
  endtask

  always @(negedge clk) begin
    obs_t o1, o3;
    if (reset !== 1'b0) begin
      model_reset();
    end else begin
      o1.g0 = bus1.m0_gnt;  o1.g1 = bus1.m1_gnt;  o1.rv0 = bus1.m0_rvalid; o1.rv1 = bus1.m1_rvalid;
      o1.en = bus1.mem_en;  o1.mwe = bus1.mem_we; o1.rd0 = bus1.m0_rdata;  o1.rd1 = bus1.m1_rdata;
      o1.maddr = bus1.mem_addr; o1.mwd = bus1.mem_wdata;
      o3.g0 = bus3.m0_gnt;  o3.g1 = bus3.m1_gnt;  o3.rv0 = bus3.m0_rvalid; o3.rv1 = bus3.m1_rvalid;
      o3.en = bus3.mem_en;  o3.mwe = bus3.mem_we; o3.rd0 = bus3.m0_rdata;  o3.rd1 = bus3.m1_rdata;
      o3.maddr = bus3.mem_addr; o3.mwd = bus3.mem_wdata;
`ifdef DMEM_ARB_PERF_EN
      o1.gr0 = bus1.m0_grants; o1.gr1 = bus1.m1_grants; o1.st0 = bus1.m0_stalls; o1.st1 = bus1.m1_stalls;
      o3.gr0 = bus3.m0_grants; o3.gr1 = bus3.m1_grants; o3.st0 = bus3.m0_stalls; o3.st1 = bus3.m1_stalls;
`endif
      model_cycle(0, 1, o1);
      model_cycle(1, 3, o3);
      cyc++;
    end
  end

  task automatic step(input logic q0, input logic [3:0] e0, input logic [31:0] ad0, input logic [31:0] dt0,
                      input logic q1, input logic [3:0] e1, input logic [31:0] ad1, input logic [31:0] dt1);
    @(posedge clk); #1;
    r0 = q0; w0 = e0; a0 = ad0; wd0 = dt0;
    r1 = q1; w1 = e1; a1 = ad1; wd1 = dt1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    r0 = 1'b0; w0 = '0; a0 = '0; wd0 = '0;
    r1 = 1'b0; w1 = '0; a1 = '0; wd1 = '0;
    @(negedge clk);
    chk("rst lat1 m0_rvalid", bus1.m0_rvalid, 0);
    chk("rst lat1 m0_rdata",  bus1.m0_rdata,  0);
    chk("rst lat1 m1_rdata",  bus1.m1_rdata,  0);
    chk("rst lat1 mem_en",    bus1.mem_en,    0);
    chk("rst lat3 m0_rvalid", bus3.m0_rvalid, 0);
    chk("rst lat3 m0_rdata",  bus3.m0_rdata,  0);
    chk("rst lat3 m1_rdata",  bus3.m1_rdata,  0);
    chk("rst lat3 mem_en",    bus3.mem_en,    0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] st_before;

  initial begin
    reset = 1'b1;
    r0 = 1'b0; w0 = '0; a0 = '0; wd0 = '0;
    r1 = 1'b0; w1 = '0; a1 = '0; wd1 = '0;
    st_before = '0;
    @(posedge clk);
    do_reset();

    // m0 read of 0x10, RD_LAT=1: rvalid two cycles after the grant
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t1 m0_gnt",   bus1.m0_gnt,   1);
    chk("t1 mem_en",   bus1.mem_en,   1);
    chk("t1 mem_we",   bus1.mem_we,   0);
    chk("t1 mem_addr", bus1.mem_addr, 32'h10);
    idle();
    chk("t1 rvalid early", bus1.m0_rvalid, 0);
    idle();
    chk("t1 m0_rvalid", bus1.m0_rvalid, 1);
    chk("t1 m0_rdata",  bus1.m0_rdata,  32'hDEADBEEF);
    chk("t1 m1_rvalid", bus1.m1_rvalid, 0);
    chk("t1 m1_rdata",  bus1.m1_rdata,  0);
    idle();
    chk("t1 rvalid one cycle", bus1.m0_rvalid, 0);
    idle();
    idle();

    // continuous writes from both: strict alternation starting with m0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF, 32'h0, 32'h11110000, 1'b1, 4'hF, 32'h4, 32'h22220000);
      chk("t2 lat1 m0_gnt",   bus1.m0_gnt,   32'((i % 2) == 0));
      chk("t2 lat1 m1_gnt",   bus1.m1_gnt,   32'((i % 2) == 1));
      chk("t2 lat1 mem_en",   bus1.mem_en,   1);
      chk("t2 lat1 mem_addr", bus1.mem_addr, ((i % 2) == 0) ? 32'h0 : 32'h4);
      chk("t2 lat3 m0_gnt",   bus3.m0_gnt,   32'((i % 2) == 0));
      chk("t2 lat3 m0_rvalid", bus3.m0_rvalid, 0);
    end
    idle();

    // m0 read, m1 write arrives next cycle and waits out the read
    step(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h55);
    chk("t3 lat1 m1_gnt blocked", bus1.m1_gnt, 0);
`ifdef DMEM_ARB_PERF_EN
    st_before = bus1.m1_stalls;
`endif
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h55);
    chk("t3 lat1 m1_gnt",    bus1.m1_gnt,    1);
    chk("t3 lat1 m0_rvalid", bus1.m0_rvalid, 1);
    chk("t3 lat3 m1_gnt blocked", bus3.m1_gnt, 0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h55);
`ifdef DMEM_ARB_PERF_EN
    chk("t3 lat1 m1_stalls delta", bus1.m1_stalls, st_before + 32'd1);
`endif
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h55);
    chk("t3 lat3 m1_gnt",    bus3.m1_gnt,    1);
    chk("t3 lat3 m0_rvalid", bus3.m0_rvalid, 1);
    idle();
    idle();

    // RD_LAT=3: m1 read of 0x20 blocks all grants for three cycles
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
    chk("t4 lat3 m1_gnt", bus3.m1_gnt, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 4'hF, 32'h80, 32'h99, 1'b0, 4'h0, 32'h0, 32'h0);
      chk("t4 lat3 m0_gnt blocked", bus3.m0_gnt,    0);
      chk("t4 lat3 mem_en",         bus3.mem_en,    0);
      chk("t4 lat3 m1_rvalid early", bus3.m1_rvalid, 0);
    end
    step(1'b1, 4'hF, 32'h80, 32'h99, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t4 lat3 m1_rvalid", bus3.m1_rvalid, 1);
    chk("t4 lat3 m1_rdata",  bus3.m1_rdata,  32'h12345678);
    chk("t4 lat3 m0_gnt",    bus3.m0_gnt,    1);
    chk("t4 lat3 m0_rdata kept", bus3.m0_rdata, 32'hDEADBEEF);
    idle();

    // reset during RD_WAIT discards the read
    step(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("t5 lat3 no rvalid", bus3.m0_rvalid, 0);
      chk("t5 lat1 no rvalid", bus1.m0_rvalid, 0);
    end
    chk("t5 lat3 m0_rdata", bus3.m0_rdata, 0);
    step(1'b1, 4'hF, 32'h0, 32'h1, 1'b1, 4'hF, 32'h4, 32'h2);
    chk("t5 lat1 tie m0", bus1.m0_gnt, 1);
    chk("t5 lat3 tie m0", bus3.m0_gnt, 1);
    idle();

    // partial byte-enable write passes through in the grant cycle only
    do_reset();
    step(1'b1, 4'b0011, 32'h8, 32'hAABBCCDD, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t6 mem_en",    bus1.mem_en,    1);
    chk("t6 mem_we",    bus1.mem_we,    32'h3);
    chk("t6 mem_addr",  bus1.mem_addr,  32'h8);
    chk("t6 mem_wdata", bus1.mem_wdata, 32'hAABBCCDD);
    idle();
    chk("t6 mem_en after",    bus1.mem_en,    0);
    chk("t6 mem_we after",    bus1.mem_we,    0);
    chk("t6 mem_addr after",  bus1.mem_addr,  0);
    chk("t6 mem_wdata after", bus1.mem_wdata, 0);
`ifdef DMEM_ARB_PERF_EN
    chk("t6 m0_grants", bus1.m0_grants, 1);
`endif
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
